// File: rtl/mcu_bus_rx_pkg.sv
// mcu_bus_rx_pkg: default parameters and FIFO entry layout shared by the MCU bus receiver
package mcu_bus_rx_pkg;
    localparam int DEF_DATA_WIDTH   = 8;
    localparam int DEF_SYNC_STAGES  = 2;
    localparam int DEF_SAMPLE_DELAY = 14;
    localparam int DEF_FIFO_DEPTH   = 16;
    // An entry is {is_cmd, data}; the command flag sits in the MSB at index data_width
    function automatic int entry_w(input int data_width);
        return data_width + 1;
    endfunction
endpackage

// File: rtl/mcu_bus_fifo.sv
// mcu_bus_fifo: synchronous first-word-fall-through FIFO with extra-MSB pointers
module mcu_bus_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       din,
    input  logic                   pop,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0] wp, rp;
    logic [WIDTH-1:0] last;
    logic wr, rd;
    assign empty = wp == rp;
    assign full  = (wp ^ rp) == {1'b1, {AW{1'b0}}};
    assign level = wp - rp;
    assign rd    = pop & ~empty;
    assign wr    = push & (~full | rd);
    // When empty the head output keeps showing the most recently popped entry
    assign dout  = empty ? last : mem[rp[AW-1:0]];
    always_ff @(posedge clk)
        if (wr) mem[wp[AW-1:0]] <= din;
    always_ff @(posedge clk)
        if (rst) begin
            wp   <= '0;
            rp   <= '0;
            last <= '0;
        end else begin
            wp   <= wr ? wp + 1'b1 : wp;
            rp   <= rd ? rp + 1'b1 : rp;
            last <= rd ? mem[rp[AW-1:0]] : last;
        end
endmodule

// File: rtl/mcu_bus_rx.sv
// mcu_bus_rx: samples the MCU bus a fixed delay after each synchronised strobe rise into a FWFT FIFO
module mcu_bus_rx
    import mcu_bus_rx_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
    parameter int SAMPLE_DELAY = DEF_SAMPLE_DELAY,
    parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
    input  logic                          sysclk,
    input  logic                          rst,
    input  logic                          busclk,
    input  logic [DATA_WIDTH-1:0]         bus,
    input  logic                          command_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic                          out_is_cmd,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic                          overrun,
    output logic                          led
);
    localparam int ENTRY_W = entry_w(DATA_WIDTH);
    localparam int CMD_BIT = DATA_WIDTH;
    localparam int CW      = $clog2(SAMPLE_DELAY + 1);
    logic [SYNC_STAGES:0] s;
    logic [CW-1:0] cnt;
    logic [ENTRY_W-1:0] head;
    logic edge_det, strobe, pop, full, empty;
    assign edge_det   = s[SYNC_STAGES-1] & ~s[SYNC_STAGES];
    // A fresh edge restarts the settle window, so it also cancels a sample due this cycle
    assign strobe     = (cnt == CW'(1)) & ~edge_det;
    assign out_valid  = ~empty;
    assign pop        = out_valid & out_ready;
    assign out_data   = head[DATA_WIDTH-1:0];
    assign out_is_cmd = head[CMD_BIT];
    always_ff @(posedge sysclk)
        if (rst) begin
            s        <= '0;
            cnt      <= '0;
            overflow <= 1'b0;
            overrun  <= 1'b0;
            led      <= 1'b0;
        end else begin
            s        <= {s[SYNC_STAGES-1:0], busclk};
            cnt      <= edge_det ? CW'(SAMPLE_DELAY) : (cnt != '0 ? cnt - CW'(1) : cnt);
            overrun  <= overrun | (edge_det & (cnt != '0));
            overflow <= overflow | (strobe & full & ~pop);
            led      <= (strobe & (&bus)) ? 1'b1 : (strobe & ~(|bus)) ? 1'b0 : led;
        end
    mcu_bus_fifo #(
        .WIDTH(ENTRY_W),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (sysclk),
        .rst  (rst),
        .push (strobe),
        .din  ({command_data, bus}),
        .pop  (pop),
        .dout (head),
        .full (full),
        .empty(empty),
        .level(fifo_level)
    );
endmodule

// File: tb/tb_mcu_bus_rx.sv
// tb_mcu_bus_rx: table-driven, hand-sequenced and randomized checks against a time-based reference model
module tb_mcu_bus_rx;
    localparam int S   = 2;
    localparam int D   = 14;
    localparam int DEP = 16;

    logic sysclk = 0, rst = 1, busclk = 0, command_data = 0, out_ready = 0;
    logic [7:0] bus = 0;
    logic out_valid, out_is_cmd, overflow, overrun, led;
    logic [7:0] out_data;
    logic [4:0] fifo_level;

    mcu_bus_rx dut (
        .sysclk(sysclk), .rst(rst), .busclk(busclk), .bus(bus), .command_data(command_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_is_cmd(out_is_cmd),
        .fifo_level(fifo_level), .overflow(overflow), .overrun(overrun), .led(led)
    );

    always #5 sysclk = ~sysclk;

    int checks = 0, failures = 0;

    // Reference model: absolute cycle numbers, pin history and a queue of entries
    logic [8:0] mq[$];
    logic [8:0] mlast;
    bit mof, mor, mled;
    int pend = -1, cyc_n = 0, last_rst = -1;
    bit pin_h [0:32767];

    typedef struct {
        logic [7:0] b;
        logic       c;
        logic       led;
    } vec_t;
    vec_t tbl [5];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc_n, act, exp);
        end
    endtask

    function automatic bit pv(input int k);
        return (k < 0 || k <= last_rst) ? 1'b0 : pin_h[k];
    endfunction

    // A strobe rise seen on the pin in cycle t becomes an edge in cycle t+S;
    // the sample is taken D cycles after the latest edge unless another edge intervenes.
    task automatic model_step();
        bit e, samp;
        if (rst) begin
            mq.delete();
            mlast = 0; mof = 0; mor = 0; mled = 0;
            pend = -1;
            last_rst = cyc_n;
            cyc_n++;
            return;
        end
        pin_h[cyc_n] = busclk;
        e = pv(cyc_n - S) && !pv(cyc_n - S - 1);
        samp = !e && pend == cyc_n;
        if (e) begin
            if (pend >= cyc_n) mor = 1;
            pend = cyc_n + D;
        end
        if (mq.size() > 0 && out_ready) mlast = mq.pop_front();
        if (samp) begin
            if (bus == 8'hFF) mled = 1;
            else if (bus == 8'h00) mled = 0;
            if (mq.size() < DEP) mq.push_back({command_data, bus});
            else mof = 1;
        end
        cyc_n++;
    endtask

    task automatic compare();
        logic [8:0] hd;
        hd = mq.size() != 0 ? mq[0] : mlast;
        check("model_out_valid", out_valid, mq.size() != 0);
        check("model_out_data", out_data, hd[7:0]);
        check("model_out_is_cmd", out_is_cmd, hd[8]);
        check("model_fifo_level", fifo_level, mq.size());
        check("model_overflow", overflow, mof);
        check("model_overrun", overrun, mor);
        check("model_led", led, mled);
    endtask

    task automatic cyc();
        model_step();
        @(negedge sysclk);
        compare();
    endtask

    task automatic do_reset();
        rst = 1;
        repeat (2) cyc();
        rst = 0;
    endtask

    // One complete strobe window of 20 cycles; sample lands on the 17th posedge
    task automatic strobe(input logic [7:0] b, input logic c, input int pop_at);
        bus = b;
        command_data = c;
        busclk = 1;
        for (int k = 1; k <= 20; k++) begin
            if (k == 3) busclk = 0;
            out_ready = (k == pop_at);
            cyc();
        end
        out_ready = 0;
    endtask

    initial begin
        int k;
        int thr;
        logic [7:0] exp_b;
        tbl[0] = '{8'hA5, 1'b1, 1'b0};
        tbl[1] = '{8'hFF, 1'b0, 1'b1};
        tbl[2] = '{8'h3C, 1'b1, 1'b1};
        tbl[3] = '{8'h00, 1'b0, 1'b0};
        tbl[4] = '{8'hC3, 1'b1, 1'b0};

        // Reset asserted mid-count with the strobe toggling
        do_reset();
        bus = 8'h5A;
        busclk = 1;
        repeat (2) cyc();
        busclk = 0;
        repeat (6) cyc();
        rst = 1;
        for (int i = 0; i < 3; i++) begin
            busclk = ~busclk;
            cyc();
        end
        check("rst_out_valid", out_valid, 0);
        check("rst_level", fifo_level, 0);
        check("rst_out_data", out_data, 0);
        rst = 0;
        busclk = 0;
        repeat (30) cyc();
        check("rst_no_entry_valid", out_valid, 0);
        check("rst_no_entry_level", fifo_level, 0);
        check("rst_overrun", overrun, 0);
        check("rst_led", led, 0);

        // Single writes, latency and led behaviour from the vector table
        for (int v = 0; v < 5; v++) begin
            bus = tbl[v].b;
            command_data = tbl[v].c;
            busclk = 1;
            k = 0;
            while (!out_valid && k < 40) begin
                if (k == 2) busclk = 0;
                cyc();
                k++;
            end
            busclk = 0;
            check("tbl_latency", k, 17);
            check("tbl_out_data", out_data, tbl[v].b);
            check("tbl_out_is_cmd", out_is_cmd, tbl[v].c);
            check("tbl_level", fifo_level, 1);
            check("tbl_led", led, tbl[v].led);
            out_ready = 1;
            cyc();
            out_ready = 0;
            check("tbl_pop_valid", out_valid, 0);
            check("tbl_pop_level", fifo_level, 0);
            check("tbl_hold_data", out_data, tbl[v].b);
            repeat (3) cyc();
        end

        // Burst until full, then one dropped sample, then drain in order
        do_reset();
        for (int i = 0; i < 16; i++) strobe(8'(i), 1'b0, -1);
        check("burst_level_full", fifo_level, 16);
        check("burst_no_overflow", overflow, 0);
        strobe(8'hEE, 1'b1, -1);
        check("burst_overflow", overflow, 1);
        check("burst_level_still_full", fifo_level, 16);
        out_ready = 1;
        for (int i = 0; i < 16; i++) begin
            check("burst_drain_data", out_data, i);
            cyc();
        end
        out_ready = 0;
        check("burst_drained", fifo_level, 0);

        // Full FIFO with push and pop in the same cycle
        do_reset();
        for (int i = 0; i < 16; i++) strobe(8'h40 + 8'(i), 1'b0, -1);
        strobe(8'hC3, 1'b1, 17);
        check("full_pp_level", fifo_level, 16);
        check("full_pp_overflow", overflow, 0);
        out_ready = 1;
        for (int i = 0; i < 16; i++) begin
            exp_b = (i < 15) ? 8'h41 + 8'(i) : 8'hC3;
            check("full_pp_drain", out_data, exp_b);
            check("full_pp_cmd", out_is_cmd, i == 15);
            cyc();
        end
        out_ready = 0;

        // Second rise five cycles after the first: overrun, only the second value survives
        do_reset();
        bus = 8'h11;
        command_data = 0;
        busclk = 1;
        repeat (2) cyc();
        busclk = 0;
        repeat (3) cyc();
        bus = 8'h22;
        command_data = 1;
        busclk = 1;
        repeat (2) cyc();
        busclk = 0;
        repeat (14) cyc();
        check("ovr_not_yet_valid", out_valid, 0);
        check("ovr_flag", overrun, 1);
        cyc();
        check("ovr_valid", out_valid, 1);
        check("ovr_data", out_data, 8'h22);
        check("ovr_level", fifo_level, 1);
        repeat (20) cyc();
        check("ovr_single_entry", fifo_level, 1);

        // Randomized traffic with phases of differing consumer readiness
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            thr = (n < 1000) ? 0 : (n < 2000) ? 1 : (n < 3000) ? 3 : 4;
            if ($urandom_range(0, 9) == 0) busclk = ~busclk;
            bus = 8'($urandom);
            command_data = 1'($urandom);
            out_ready = $urandom_range(0, 3) < thr;
            rst = $urandom_range(0, 699) == 0;
            cyc();
        end
        rst = 0;
        out_ready = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end
endmodule
